// File: rtl/sha1_wb_host.sv
// Wishbone master that drives a memory-mapped SHA-1 core: enable, load one 512-bit
// block, poll for completion, read back the 160-bit digest. Define SHA1_HOST_TIMEOUT_EN for ack/poll timeouts.
module sha1_wb_host #(
  parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
  parameter logic [15:0] POLL_LIMIT   = 16'd1024,
  parameter logic [7:0]  ACK_LIMIT    = 8'd64
) (
  input  logic         wb_clk_i,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] message,
  output logic         busy,
  output logic [159:0] digest,
  output logic         digest_valid,
  output logic         error,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic         wbm_ack_i,
  input  logic [31:0]  wbm_dat_i
);

  typedef enum logic [2:0] {IDLE, WR_ON, WR_MSG, POLL, RD_DIG, GAP, DONE, ERROR} state_e;

  localparam logic [31:0] ADR_CTRL      = BASE_ADDRESS + 32'h8;
  localparam logic [31:0] ADR_MSG       = BASE_ADDRESS + 32'hC;
  localparam logic [31:0] ADR_DIG       = BASE_ADDRESS + 32'h10;
  localparam logic [31:0] CTRL_ON       = 32'h0000_0001;
  localparam logic [31:0] DIG_NOT_READY = 32'hffff_fff0;
  localparam int          STATUS_DONE   = 3;

  state_e        state_q, state_d;
  state_e        ret_q, ret_d;     // where GAP goes once its idle cycle is spent
  logic [511:0]  msg_q;
  logic [3:0]    msg_cnt;
  logic [2:0]    dig_cnt;
  logic [127:0]  dig_buf;
  logic          bus_active;
  logic          status_done;
  logic          dig_not_ready;
  logic          ack_expired;
  logic          poll_expired;

  assign bus_active    = state_q inside {WR_ON, WR_MSG, POLL, RD_DIG};
  assign status_done   = wbm_dat_i[STATUS_DONE];
  assign dig_not_ready = (wbm_dat_i == DIG_NOT_READY);

`ifdef SHA1_HOST_TIMEOUT_EN
  logic [15:0] poll_cnt;
  logic [7:0]  ack_wait;

  assign ack_expired  = bus_active && !wbm_ack_i && (ack_wait >= ACK_LIMIT - 8'd1);
  assign poll_expired = (poll_cnt >= POLL_LIMIT - 16'd1);

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      poll_cnt <= '0;
      ack_wait <= '0;
    end else begin
      if (state_q == IDLE && start)
        poll_cnt <= '0;
      else if (state_q == POLL && wbm_ack_i && !status_done && poll_cnt != '1)
        poll_cnt <= poll_cnt + 16'd1;
      if (bus_active && !wbm_ack_i) begin
        if (ack_wait != '1)
          ack_wait <= ack_wait + 8'd1;
      end else begin
        ack_wait <= '0;
      end
    end
  end
`else
  // The limits only matter when timeouts are built in.
  logic unused_limits;
  assign unused_limits = ^{POLL_LIMIT, ACK_LIMIT};
  assign ack_expired   = 1'b0;
  assign poll_expired  = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    case (state_q)
      IDLE:   if (start) state_d = WR_ON;
      WR_ON: begin
        if (wbm_ack_i) begin
          state_d = GAP;
          ret_d   = WR_MSG;
        end else if (ack_expired) begin
          state_d = ERROR;
        end
      end
      WR_MSG: begin
        if (wbm_ack_i) begin
          state_d = GAP;
          ret_d   = (msg_cnt == 4'd15) ? POLL : WR_MSG;
        end else if (ack_expired) begin
          state_d = ERROR;
        end
      end
      POLL: begin
        if (wbm_ack_i) begin
          if (status_done) begin
            state_d = GAP;
            ret_d   = RD_DIG;
          end else if (poll_expired) begin
            state_d = ERROR;
          end else begin
            state_d = GAP;
            ret_d   = POLL;
          end
        end else if (ack_expired) begin
          state_d = ERROR;
        end
      end
      RD_DIG: begin
        if (wbm_ack_i) begin
          if (dig_not_ready) begin
            state_d = GAP;
            ret_d   = POLL;
          end else if (dig_cnt == 3'd4) begin
            state_d = DONE;
          end else begin
            state_d = GAP;
            ret_d   = RD_DIG;
          end
        end else if (ack_expired) begin
          state_d = ERROR;
        end
      end
      GAP:     state_d = ret_q;
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the message latch has no reset; it is always reloaded by a start before it is read.
  always_ff @(posedge wb_clk_i) begin
    if (state_q == IDLE && start)
      msg_q <= message;
  end

  // Words 0..3 are staged so digest changes only when a full, valid readout completes.
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      msg_cnt <= '0;
      dig_cnt <= '0;
      dig_buf <= '0;
      digest  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            msg_cnt <= '0;
            dig_cnt <= '0;
          end
        end
        WR_MSG: if (wbm_ack_i) msg_cnt <= msg_cnt + 4'd1;
        RD_DIG: begin
          if (wbm_ack_i) begin
            if (dig_not_ready) begin
              dig_cnt <= '0;
            end else if (dig_cnt == 3'd4) begin
              digest  <= {wbm_dat_i, dig_buf};
              dig_cnt <= '0;
            end else begin
              dig_buf[{dig_cnt[1:0], 5'd0} +: 32] <= wbm_dat_i;
              dig_cnt <= dig_cnt + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wbm_cyc_o    = bus_active;
    wbm_stb_o    = bus_active;
    wbm_we_o     = (state_q == WR_ON) || (state_q == WR_MSG);
    wbm_sel_o    = bus_active ? 4'hF : 4'h0;
    wbm_adr_o    = '0;
    wbm_dat_o    = '0;
    case (state_q)
      WR_ON: begin
        wbm_adr_o = ADR_CTRL;
        wbm_dat_o = CTRL_ON;
      end
      WR_MSG: begin
        wbm_adr_o = ADR_MSG;
        wbm_dat_o = msg_q[{msg_cnt, 5'd0} +: 32];
      end
      POLL:    wbm_adr_o = ADR_CTRL;
      RD_DIG:  wbm_adr_o = ADR_DIG;
      default: ;
    endcase
    busy         = bus_active || (state_q == GAP);
    digest_valid = (state_q == DONE);
`ifdef SHA1_HOST_TIMEOUT_EN
    error        = (state_q == ERROR);
`else
    error        = 1'b0;
`endif
  end

endmodule

// File: doc/sha1_wb_host.md
SHA1_WB_HOST -- requirements
Module: sha1_wb_host

Interface
REQ-001 Parameter BASE_ADDRESS, default 32'h30000024, SHALL be the base of the SHA1 peripheral register window.
REQ-002 Parameter POLL_LIMIT, default 16'd1024, SHALL be the maximum number of status reads per hash.
REQ-003 Parameter ACK_LIMIT, default 8'd64, SHALL be the maximum number of cycles to wait for wbm_ack_i per bus cycle.
REQ-004 wb_clk_i  in  1  SHALL be the single clock; all logic on its rising edge.
REQ-005 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-006 start  in  1  SHALL request one hash; sampled only in IDLE.
REQ-007 message  in  512  SHALL be the block to hash, latched on accepted start.
REQ-008 busy  out  1  SHALL be high from accepted start until DONE or ERROR is entered.
REQ-009 digest  out  160  SHALL hold the last digest, word k in bits [32k+31:32k].
REQ-010 digest_valid  out  1  SHALL be a one-cycle pulse when digest is complete.
REQ-011 error  out  1  SHALL be a one-cycle pulse on timeout abort.
REQ-012 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  SHALL be the Wishbone master cycle, strobe and write-enable.
REQ-013 wbm_sel_o  out  4  SHALL be 4'hF whenever wbm_stb_o is high, else 4'h0.
REQ-014 wbm_adr_o, wbm_dat_o  out  32 each  SHALL be the address and write data.
REQ-015 wbm_ack_i  in  1, wbm_dat_i  in  32  SHALL be the peripheral acknowledge and read data.

Function
REQ-016 The FSM SHALL use states IDLE, WR_ON, WR_MSG, POLL, RD_DIG, GAP, DONE, ERROR.
REQ-017 Every bus cycle SHALL assert cyc/stb with stable adr/we/dat until the cycle wbm_ack_i is sampled high, then deassert cyc/stb for exactly one GAP cycle.
REQ-018 At most one bus cycle SHALL be outstanding; ack when stb is low SHALL be ignored.
REQ-019 IDLE + start: latch message, clear msg/digest counters, go to WR_ON.
REQ-020 WR_ON: write 32'h00000001 to BASE_ADDRESS+8; on ack go to WR_MSG.
REQ-021 WR_MSG: 16 writes to BASE_ADDRESS+'hC, write n (0..15) carrying message[32n+31:32n]; after write 15 acks go to POLL.
REQ-022 POLL: read BASE_ADDRESS+8; ack data bit 3 set -> RD_DIG; clear -> reissue read after GAP, incrementing the poll counter.
REQ-023 RD_DIG: 5 reads of BASE_ADDRESS+'h10; read k data stored into digest word k; read value 32'hfffffff0 SHALL be treated as not-ready, return to POLL, and restart from k=0.
REQ-024 After the 5th digest read ack: DONE for one cycle (digest_valid=1), then IDLE.
REQ-025 ERROR SHALL last one cycle (error=1, cyc/stb low), then IDLE; digest SHALL keep its previous value.
REQ-026 start while not IDLE SHALL be ignored; start in DONE/ERROR cycle SHALL be ignored.
REQ-027 digest SHALL update only on completed RD_DIG acks; digest_valid and error SHALL never be high together.
REQ-028 Poll counter and ack-wait counter SHALL saturate, never wrap.

Reset
REQ-029 On reset, state=IDLE; busy, digest_valid, error, wbm_cyc_o, wbm_stb_o, wbm_we_o=0; wbm_sel_o=0; wbm_adr_o, wbm_dat_o=0; digest=0; all counters=0.
REQ-030 Reset mid-transfer SHALL drop cyc/stb on the next edge and discard any in-flight ack.

Configuration
REQ-031 With SHA1_HOST_TIMEOUT_EN defined: ACK_LIMIT cycles without ack, or POLL_LIMIT polls without DONE, SHALL abort to ERROR (cyc/stb dropped the next cycle).
REQ-032 Without SHA1_HOST_TIMEOUT_EN: no counters built, waits are unbounded, error SHALL be tied 0.

Verification
REQ-033 Responder model acking 1 cycle after stb; start with message=512'h...61626380 pattern -> exactly 1 ON write, 16 MSG writes in order word0..15, polls, 5 digest reads, digest_valid pulse once, digest matches model.
REQ-034 Responder returns bit3=0 for 3 polls then 1 -> exactly 4 POLL reads, one GAP cycle between each.
REQ-035 First digest read returns 32'hfffffff0 -> returns to POLL, then 5 fresh reads; final digest equals model.
REQ-036 Responder never acks WR_MSG write 7, timeout enabled, ACK_LIMIT=64 -> error pulse 64 cycles after stb rise, cyc/stb low next cycle, busy low.
REQ-037 reset asserted during WR_MSG write 5 -> next edge cyc/stb=0, busy=0; new start performs full sequence from WR_ON.
REQ-038 start held high continuously -> back-to-back hashes, each separated by DONE and IDLE cycles; start pulses during busy produce no extra bus cycles.
